// File: rtl/raster_stamp_buf_pkg.sv
// Shared raster types: stamp entry, CSR response and response FSM states.
// RASTER_GRAD_EN adds per-stamp z-gradients to the CSR response.
package raster_stamp_buf_pkg;

`ifndef RASTER_STAMP_LANES
`define RASTER_STAMP_LANES 4
`endif

  localparam int RASTER_POS_Y_LSB = 16;
  localparam int RASTER_MASK_LSB  = 0;
  localparam int STAMP_LANES      = `RASTER_STAMP_LANES;

  typedef struct packed {
    logic [15:0]               pid;
    logic [STAMP_LANES*32-1:0] bcoord_z;
    logic [STAMP_LANES*32-1:0] bcoord_y;
    logic [STAMP_LANES*32-1:0] bcoord_x;
    logic [STAMP_LANES-1:0]    mask;
    logic [15:0]               pos_y;
    logic [15:0]               pos_x;
  } raster_stamp_t;

  typedef struct packed {
`ifdef RASTER_GRAD_EN
    logic [31:0] grad_y;
    logic [31:0] grad_x;
`endif
    logic [31:0] pid_mask;
    logic [31:0] pos_y_x;
  } raster_csrs_t;

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_STAMP,
    RSP_DONE
  } rsp_state_t;

endpackage

// File: rtl/raster_stamp_buf_if.sv
// Stamp input, fetch request and CSR response bundle.
interface raster_stamp_buf_if #(
  parameter int NUM_LANES = 4,
  parameter int POS_BITS  = 16,
  parameter int PID_BITS  = 16,
  parameter int DEPTH     = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [POS_BITS-1:0]    in_pos_x;
  logic [POS_BITS-1:0]    in_pos_y;
  logic [NUM_LANES-1:0]   in_mask;
  logic [NUM_LANES*32-1:0] in_bcoord_x;
  logic [NUM_LANES*32-1:0] in_bcoord_y;
  logic [NUM_LANES*32-1:0] in_bcoord_z;
  logic [PID_BITS-1:0]    in_pid;
  logic                   raster_done;
  logic                   req_valid;
  logic                   req_ready;
  logic                   rsp_valid;
  logic                   rsp_done;
  logic [31:0]            rsp_pos_y_x;
  logic [31:0]            rsp_pid_mask;
  logic [NUM_LANES*32-1:0] rsp_bcoord_x;
  logic [NUM_LANES*32-1:0] rsp_bcoord_y;
  logic [NUM_LANES*32-1:0] rsp_bcoord_z;
  logic [31:0]            rsp_grad_x;
  logic [31:0]            rsp_grad_y;
  logic [$clog2(DEPTH):0] count;

  modport master (
    output in_valid, in_pos_x, in_pos_y, in_mask,
    output in_bcoord_x, in_bcoord_y, in_bcoord_z, in_pid,
    output raster_done, req_valid,
    input  in_ready, req_ready, rsp_valid, rsp_done,
    input  rsp_pos_y_x, rsp_pid_mask,
    input  rsp_bcoord_x, rsp_bcoord_y, rsp_bcoord_z,
    input  rsp_grad_x, rsp_grad_y, count
  );

  modport slave (
    input  in_valid, in_pos_x, in_pos_y, in_mask,
    input  in_bcoord_x, in_bcoord_y, in_bcoord_z, in_pid,
    input  raster_done, req_valid,
    output in_ready, req_ready, rsp_valid, rsp_done,
    output rsp_pos_y_x, rsp_pid_mask,
    output rsp_bcoord_x, rsp_bcoord_y, rsp_bcoord_z,
    output rsp_grad_x, rsp_grad_y, count
  );
endinterface

// File: rtl/raster_stamp_buf_fifo.sv
// Generic FIFO storage; head is visible combinationally on data_out.
module raster_stamp_buf_fifo #(
  parameter int DATAW = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATAW-1:0]       data_in,
  output logic [DATAW-1:0]       data_out,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  assign data_out = mem[rd_ptr];
endmodule

// File: rtl/raster_stamp_buf.sv
// Stamp FIFO between raster core and CSR fetch; RASTER_GRAD_EN enables gradients.
module raster_stamp_buf
  import raster_stamp_buf_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int DEPTH     = 8,
  parameter int POS_BITS  = 16,
  parameter int PID_BITS  = 16
) (
  input logic         clk,
  input logic         reset,
  raster_stamp_buf_if.slave bus
);
  localparam int LW = NUM_LANES * 32;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
`ifdef RASTER_GRAD_EN
    logic [31:0]          grad_y;
    logic [31:0]          grad_x;
`endif
    logic [PID_BITS-1:0]  pid;
    logic [LW-1:0]        bz;
    logic [LW-1:0]        by;
    logic [LW-1:0]        bx;
    logic [NUM_LANES-1:0] mask;
    logic [POS_BITS-1:0]  y;
    logic [POS_BITS-1:0]  x;
  } entry_t;

  entry_t       wr;
  entry_t       rd;
  logic [CW-1:0] cnt;
  logic         empty, full, push, pop, fire;
  rsp_state_t   state, state_n;
  raster_csrs_t csr_n, csr_q;
  logic [LW-1:0] bx_q, by_q, bz_q;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign push  = bus.in_valid && !full;
  assign fire  = bus.req_valid && bus.req_ready;
  assign pop   = fire && !empty;

  assign bus.in_ready  = !full;
  assign bus.req_ready = !empty || bus.raster_done;
  assign bus.count     = cnt;

  always_comb begin
    wr      = '0;
    wr.x    = bus.in_pos_x;
    wr.y    = bus.in_pos_y;
    wr.mask = bus.in_mask;
    wr.bx   = bus.in_bcoord_x;
    wr.by   = bus.in_bcoord_y;
    wr.bz   = bus.in_bcoord_z;
    wr.pid  = bus.in_pid;
`ifdef RASTER_GRAD_EN
    wr.grad_x = bus.in_bcoord_z[32 +: 32] - bus.in_bcoord_z[0 +: 32];
    wr.grad_y = bus.in_bcoord_z[64 +: 32] - bus.in_bcoord_z[0 +: 32];
`endif
  end

  raster_stamp_buf_fifo #(
    .DATAW ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .data_in  (wr),
    .data_out (rd),
    .count    (cnt)
  );

  always_comb begin
    csr_n = '0;
    csr_n.pos_y_x[0 +: POS_BITS] = rd.x;
    csr_n.pos_y_x[RASTER_POS_Y_LSB +: POS_BITS] = rd.y;
    csr_n.pid_mask[RASTER_MASK_LSB +: NUM_LANES] = rd.mask;
    csr_n.pid_mask[RASTER_MASK_LSB + NUM_LANES +: PID_BITS] = rd.pid;
`ifdef RASTER_GRAD_EN
    csr_n.grad_x = rd.grad_x;
    csr_n.grad_y = rd.grad_y;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RSP_IDLE;
    else       state <= state_n;
  end

  // Buffered stamps win over end-of-stream.
  always_comb begin
    state_n = RSP_IDLE;
    if (fire) state_n = empty ? RSP_DONE : RSP_STAMP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csr_q <= '0;
      bx_q  <= '0;
      by_q  <= '0;
      bz_q  <= '0;
    end else if (fire) begin
      if (empty) begin
        csr_q <= '0;
        bx_q  <= '0;
        by_q  <= '0;
        bz_q  <= '0;
      end else begin
        csr_q <= csr_n;
        bx_q  <= rd.bx;
        by_q  <= rd.by;
        bz_q  <= rd.bz;
      end
    end
  end

  assign bus.rsp_valid    = (state != RSP_IDLE);
  assign bus.rsp_done     = (state == RSP_DONE);
  assign bus.rsp_pos_y_x  = csr_q.pos_y_x;
  assign bus.rsp_pid_mask = csr_q.pid_mask;
  assign bus.rsp_bcoord_x = bx_q;
  assign bus.rsp_bcoord_y = by_q;
  assign bus.rsp_bcoord_z = bz_q;
`ifdef RASTER_GRAD_EN
  assign bus.rsp_grad_x   = csr_q.grad_x;
  assign bus.rsp_grad_y   = csr_q.grad_y;
`else
  assign bus.rsp_grad_x   = 32'd0;
  assign bus.rsp_grad_y   = 32'd0;
`endif
endmodule

// File: tb/tb_raster_stamp_buf.sv
// Directed bench for raster_stamp_buf (default parameters).
module tb_raster_stamp_buf;
  localparam int NL = 4;
  localparam int D  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] gx_exp, gy_exp;

  always #5 clk = ~clk;

  raster_stamp_buf_if #(
    .NUM_LANES(NL), .POS_BITS(16), .PID_BITS(16), .DEPTH(D)
  ) bus ();

  raster_stamp_buf #(
    .NUM_LANES(NL), .DEPTH(D), .POS_BITS(16), .PID_BITS(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_stamp(input logic [15:0] x, input logic [15:0] y,
                           input logic [3:0] m, input logic [15:0] pid,
                           input logic [31:0] z0, input logic [31:0] z1,
                           input logic [31:0] z2, input logic [31:0] z3);
    bus.in_pos_x = x;
    bus.in_pos_y = y;
    bus.in_mask  = m;
    bus.in_pid   = pid;
    for (int i = 0; i < NL; i++)
      bus.in_bcoord_x[32*i +: 32] = {pid, 16'(i)};
    bus.in_bcoord_y = '0;
    bus.in_bcoord_z = {z3, z2, z1, z0};
  endtask

  function automatic logic [31:0] pm(input int pid, input int m);
    return 32'((pid << 4) | m);
  endfunction

  initial begin
`ifdef RASTER_GRAD_EN
    gx_exp = 32'd30;
    gy_exp = 32'hFFFF_FFF6;
`else
    gx_exp = 32'd0;
    gy_exp = 32'd0;
`endif
    bus.in_valid = 1'b0;
    bus.req_valid = 1'b0;
    bus.raster_done = 1'b0;
    set_stamp(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_count", bus.count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_done", bus.rsp_done, 0);
    chk("rst_pos", bus.rsp_pos_y_x, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // single stamp round trip
    set_stamp(5, 9, 4'b1011, 3, 100, 130, 90, 7);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("t1_count", bus.count, 1);
    bus.req_valid = 1'b1;
    #1;
    chk("t1_req_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    chk("t1_valid", bus.rsp_valid, 1);
    chk("t1_done", bus.rsp_done, 0);
    chk("t1_pos", bus.rsp_pos_y_x, 32'h0009_0005);
    chk("t1_pidmask", bus.rsp_pid_mask, 32'h0000_003B);
    chk("t1_bx", bus.rsp_bcoord_x,
        128'h0003_0003_0003_0002_0003_0001_0003_0000);
    chk("t1_bz", bus.rsp_bcoord_z,
        {32'd7, 32'd90, 32'd130, 32'd100});
    chk("t1_gx", bus.rsp_grad_x, gx_exp);
    chk("t1_gy", bus.rsp_grad_y, gy_exp);
    chk("t1_count0", bus.count, 0);
    tick();
    chk("t1_pulse", bus.rsp_valid, 0);
    chk("t1_hold", bus.rsp_pos_y_x, 32'h0009_0005);

    // fill to full, overflow attempt, then drain
    for (int i = 0; i < D; i++) begin
      set_stamp(16'(i), 16'(i), 4'hF, 16'(10 + i), 0, 0, 0, 0);
      bus.in_valid = 1'b1;
      tick();
    end
    chk("full_count", bus.count, D);
    chk("full_in_ready", bus.in_ready, 0);
    set_stamp(1, 1, 4'hF, 99, 0, 0, 0, 0);
    tick();
    bus.in_valid = 1'b0;
    chk("full_hold", bus.count, D);
    bus.req_valid = 1'b1;
    tick();
    chk("pop_count", bus.count, D - 1);
    chk("pop_in_ready", bus.in_ready, 1);
    chk("pop_pid", bus.rsp_pid_mask, pm(10, 15));
    for (int i = 1; i < D; i++) begin
      tick();
      chk("drain_pid", bus.rsp_pid_mask, pm(10 + i, 15));
    end
    bus.req_valid = 1'b0;
    chk("drain_count", bus.count, 0);

    // streaming push+pop with pointer wrap
    for (int i = 0; i < 2; i++) begin
      set_stamp(0, 0, 4'h1, 16'(20 + i), 0, 0, 0, 0);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_stamp(0, 0, 4'h1, 16'(22 + i), 0, 0, 0, 0);
      tick();
      chk("stream_count", bus.count, 2);
      chk("stream_pid", bus.rsp_pid_mask, pm(20 + i, 1));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("tail_pid0", bus.rsp_pid_mask, pm(40, 1));
    tick();
    bus.req_valid = 1'b0;
    chk("tail_pid1", bus.rsp_pid_mask, pm(41, 1));
    chk("tail_count", bus.count, 0);

    // end-of-stream behaviour
    chk("eos_req_ready0", bus.req_ready, 0);
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("eos_no_rsp", bus.rsp_valid, 0);
    bus.raster_done = 1'b1;
    #1;
    chk("eos_req_ready1", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("eos_valid", bus.rsp_valid, 1);
    chk("eos_done", bus.rsp_done, 1);
    chk("eos_pos", bus.rsp_pos_y_x, 0);
    chk("eos_pidmask", bus.rsp_pid_mask, 0);
    chk("eos_bx", bus.rsp_bcoord_x, 0);
    chk("eos_gx", bus.rsp_grad_x, 0);
    for (int i = 0; i < 2; i++) begin
      set_stamp(16'(i), 2, 4'h6, 16'(50 + i), 0, 0, 0, 0);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.req_valid = 1'b1;
    tick();
    chk("eos_s0_done", bus.rsp_done, 0);
    chk("eos_s0_pid", bus.rsp_pid_mask, pm(50, 6));
    tick();
    chk("eos_s1_done", bus.rsp_done, 0);
    chk("eos_s1_pid", bus.rsp_pid_mask, pm(51, 6));
    chk("eos_s1_pos", bus.rsp_pos_y_x, 32'h0002_0001);
    tick();
    bus.req_valid = 1'b0;
    bus.raster_done = 1'b0;
    chk("eos_last_valid", bus.rsp_valid, 1);
    chk("eos_last_done", bus.rsp_done, 1);

    // asynchronous reset with a pending request
    for (int i = 0; i < 6; i++) begin
      set_stamp(7, 8, 4'h3, 16'(60 + i), 0, 0, 0, 0);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.req_valid = 1'b1;
    tick();
    chk("ar_pid", bus.rsp_pid_mask, pm(60, 3));
    chk("ar_count5", bus.count, 5);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_count0", bus.count, 0);
    chk("ar_valid0", bus.rsp_valid, 0);
    chk("ar_in_ready", bus.in_ready, 1);
    chk("ar_pidmask0", bus.rsp_pid_mask, 0);
    tick();
    chk("ar_no_rsp", bus.rsp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = 1'b0;
    tick();
    chk("ar_after_valid", bus.rsp_valid, 0);
    chk("ar_after_count", bus.count, 0);
    chk("ar_after_req_ready", bus.req_ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
